// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled 32-bit up-counter with compare match,
// optional auto-reload and a level interrupt. Sits on the CPU data bus.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // Architectural state
  logic [2:0]  ctrl_reg;      // [0]EN [1]AUTO_RELOAD [2]IRQ_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] prescale_reg;
  logic [31:0] pcnt_reg;
  logic        match_reg;

  // Next-state values
  logic [2:0]  ctrl_next;
  logic [31:0] count_next;
  logic [31:0] compare_next;
  logic [31:0] prescale_next;
  logic [31:0] pcnt_next;
  logic        match_next;

  // Bus decode
  logic        hit;
  logic        wr;
  logic [2:0]  offset;
  logic [31:0] lane_mask;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_prescale;

  // Timer events
  logic        tick;
  logic        is_match;

  // Byte offset bits within a word carry no meaning for this word-wide window
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign hit    = ce && (addr[31:5] == BASE_ADDR[31:5]);
  assign wr     = hit && we;
  assign offset = addr[4:2];

  assign wr_ctrl     = wr && (offset == OFF_CTRL);
  assign wr_count    = wr && (offset == OFF_COUNT);
  assign wr_compare  = wr && (offset == OFF_COMPARE);
  assign wr_status   = wr && (offset == OFF_STATUS);
  assign wr_prescale = wr && (offset == OFF_PRESCALE);

  // Expand the byte-lane selects into a per-bit write mask
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{sel[gi]}};
    end
  endgenerate

  // Tick and match are judged on the values held before this edge, so a
  // same-edge CPU write never hides a pending match.
  assign tick     = ctrl_reg[0] && (pcnt_reg == prescale_reg);
  assign is_match = tick && (count_reg == compare_reg);

  assign irq_o = match_reg && ctrl_reg[2];

  // Next-state logic: tick effects first, CPU writes layered on top
  always_comb begin
    ctrl_next     = ctrl_reg;
    count_next    = count_reg;
    compare_next  = compare_reg;
    prescale_next = prescale_reg;
    pcnt_next     = pcnt_reg + 32'd1;
    match_next    = match_reg;

    if (tick) begin
      if (is_match && ctrl_reg[1]) begin
        count_next = 32'd0;
      end else begin
        count_next = count_reg + 32'd1;
      end
    end
    if (wr_count) begin
      count_next = (count_reg & ~lane_mask) | (data_i & lane_mask);
    end

    if (wr_ctrl && sel[0]) begin
      ctrl_next = data_i[2:0];
    end
    if (wr_compare) begin
      compare_next = (compare_reg & ~lane_mask) | (data_i & lane_mask);
    end
    if (wr_prescale) begin
      prescale_next = (prescale_reg & ~lane_mask) | (data_i & lane_mask);
    end

    if (!ctrl_reg[0] || tick || wr_ctrl || wr_prescale) begin
      pcnt_next = 32'd0;
    end

    // A match on this edge outranks a software clear
    if (is_match) begin
      match_next = 1'b1;
    end else if (wr_status && sel[0] && data_i[0]) begin
      match_next = 1'b0;
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_reg     <= 3'd0;
      count_reg    <= 32'd0;
      compare_reg  <= 32'd0;
      prescale_reg <= 32'd0;
      pcnt_reg     <= 32'd0;
      match_reg    <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      match_reg    <= match_next;
    end
  end

  // Zero-wait-state read mux; full word regardless of byte lanes
  always_comb begin
    data_o = 32'd0;
    if (hit && !we) begin
      case (offset)
        OFF_CTRL:     data_o = {29'd0, ctrl_reg};
        OFF_COUNT:    data_o = count_reg;
        OFF_COMPARE:  data_o = compare_reg;
        OFF_STATUS:   data_o = {31'd0, match_reg};
        OFF_PRESCALE: data_o = prescale_reg;
        default:      data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed plus randomized bus traffic against a behavioural
// timer model; expectations queued by the driver, checked by a monitor.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  bus_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .sel(sel),
    .addr(addr), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: what the bus should show during one cycle
  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model state (register file as seen by software)
  logic [2:0]  m_ctrl;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic [31:0] m_prescale;
  logic [31:0] m_div;      // cycles elapsed in the current prescale period
  logic        m_match;

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_count;
      3'd2:    return m_compare;
      3'd3:    return {31'd0, m_match};
      3'd4:    return m_prescale;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Advance the model by one clock edge given the bus inputs of that cycle
  task automatic model_step(input logic r, input logic c, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    logic        h;
    logic [2:0]  off;
    logic        tk;
    logic        hit_cmp;
    logic [31:0] c_old;
    if (!r) begin
      m_ctrl = 0; m_count = 0; m_compare = 0; m_prescale = 0; m_div = 0; m_match = 0;
      return;
    end
    h   = c && (a[31:5] == BASE[31:5]) && w;
    off = a[4:2];
    // A period of PRESCALE+1 enabled cycles produces one tick
    tk      = m_ctrl[0] && (m_div + 1 == m_prescale + 1);
    c_old   = m_count;
    hit_cmp = tk && (c_old == m_compare);
    if (tk) m_count = (hit_cmp && m_ctrl[1]) ? 32'd0 : c_old + 1;
    if (hit_cmp) m_match = 1'b1;
    if (!m_ctrl[0] || tk) m_div = 0; else m_div = m_div + 1;
    if (h) begin
      case (off)
        3'd0: begin if (s[0]) m_ctrl = d[2:0]; m_div = 0; end
        3'd1: m_count = lanes(c_old, d, s);
        3'd2: m_compare = lanes(m_compare, d, s);
        3'd3: if (s[0] && d[0] && !hit_cmp) m_match = 1'b0;
        3'd4: begin m_prescale = lanes(m_prescale, d, s); m_div = 0; end
        default: ;
      endcase
    end
  endtask

  // One bus cycle: queue the expectation, then let the edge happen
  task automatic bus(input logic c, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, input string tag, input bit use_const,
                     input logic [31:0] cval);
    exp_t e;
    logic h;
    ce = c; we = w; sel = s; addr = a; data_i = d;
    h      = c && (a[31:5] == BASE[31:5]);
    e.tag  = tag;
    e.data = use_const ? cval : ((h && !w) ? model_read(a[4:2]) : 32'd0);
    e.irq  = m_match && m_ctrl[2];
    sb_q.push_back(e);
    @(posedge clk);
    model_step(rst, c, w, s, a, d);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, 1'b1, s, BASE + {27'd0, off, 2'b00}, d, "write", 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] off, input string tag);
    bus(1'b1, 1'b0, 4'hF, BASE + {27'd0, off, 2'b00}, 32'd0, tag, 1'b0, 32'd0);
  endtask

  task automatic rd_const(input logic [2:0] off, input logic [31:0] v, input string tag);
    bus(1'b1, 1'b0, 4'hF, BASE + {27'd0, off, 2'b00}, 32'd0, tag, 1'b1, v);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, "idle", 1'b0, 32'd0);
  endtask

  // Monitor: compare what the DUT shows against the queued expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_txn++;
      $display("txn %0d %s: data_o=%h irq_o=%b", n_txn, e.tag, data_o, irq_o);
      n_checks++;
      if (data_o !== e.data) begin
        n_fail++;
        $display("FAIL %s data: data_o=%h required %h", e.tag, data_o, e.data);
      end
      n_checks++;
      if (irq_o !== e.irq) begin
        n_fail++;
        $display("FAIL %s irq: irq_o=%b required %b", e.tag, irq_o, e.irq);
      end
    end
  end

  initial begin
    logic [31:0] cnt_seq [6];
    logic [31:0] ps_seq [9];
    cnt_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    ps_seq  = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2};
    rst = 1'b0; ce = 0; we = 0; sel = 0; addr = 0; data_i = 0;
    m_ctrl = 0; m_count = 0; m_compare = 0; m_prescale = 0; m_div = 0; m_match = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: reset in the middle of counting, with a bus write that must be ignored
    wr(3'd2, 32'd1, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    repeat (4) idle();
    rst = 1'b0;
    wr(3'd2, 32'h1234_5678, 4'hF);
    idle();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) rd_const(i[2:0], 32'd0, "reset_read");

    // 2: byte-lane writes
    wr(3'd2, 32'hAABB_CCDD, 4'hF);
    wr(3'd2, 32'h1122_3344, 4'b0101);
    rd_const(3'd2, 32'hAA22_CC44, "lane_merge");

    // 3: auto-reload period of 4 ticks with IRQ
    wr(3'd2, 32'd3, 4'hF);
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'h7, 4'hF);
    for (int i = 0; i < 6; i++) rd_const(3'd1, cnt_seq[i], "autoreload_count");
    rd_const(3'd3, 32'd1, "match_held");

    // 4: W1C clears a standing match; W1C coinciding with a match loses
    wr(3'd0, 32'h4, 4'hF);
    wr(3'd3, 32'd1, 4'hF);
    rd_const(3'd3, 32'd0, "w1c_clear");
    wr(3'd1, 32'd3, 4'hF);
    wr(3'd0, 32'h7, 4'hF);
    wr(3'd3, 32'd1, 4'hF);
    rd_const(3'd3, 32'd1, "w1c_vs_match");

    // 5: prescale by 3, then freeze
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd3, 32'd1, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd2, 32'h0000_FFFF, 4'hF);
    wr(3'd4, 32'd2, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    for (int i = 0; i < 9; i++) rd_const(3'd1, ps_seq[i], "prescale_count");
    wr(3'd0, 32'd0, 4'hF);
    repeat (4) rd(3'd1, "frozen_count");

    // 6: out-of-window, unmapped and disabled accesses
    bus(1'b1, 1'b1, 4'hF, BASE + 32'h20, 32'hFFFF_FFFF, "wr_outside", 1'b0, 32'd0);
    bus(1'b1, 1'b1, 4'hF, BASE + 32'h14, 32'hFFFF_FFFF, "wr_unmapped", 1'b0, 32'd0);
    bus(1'b0, 1'b1, 4'hF, BASE + 32'h08, 32'h0000_0001, "wr_ce0", 1'b0, 32'd0);
    bus(1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'd0, "rd_outside", 1'b1, 32'd0);
    bus(1'b1, 1'b0, 4'hF, BASE + 32'h14, 32'd0, "rd_unmapped", 1'b1, 32'd0);
    bus(1'b0, 1'b0, 4'hF, BASE + 32'h08, 32'd0, "rd_ce0", 1'b1, 32'd0);
    rd_const(3'd2, 32'h0000_FFFF, "compare_kept");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  off;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        c;
      logic        w;
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      off = 3'($urandom_range(0, 7));
      a   = BASE + {27'd0, off, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a = a + 32'h20 * $urandom_range(1, 4);
      c   = ($urandom_range(0, 9) != 0);
      w   = $urandom_range(0, 1) == 1;
      s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      case (off)
        3'd1:    d = $urandom_range(0, 24);
        3'd2:    d = $urandom_range(0, 20);
        3'd4:    d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      bus(c, w, s, a, d, "random", 1'b0, 32'd0);
    end
    rst = 1'b1;
    idle();
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
